// File: rtl/posit_pkg.sv
// Shared posit helpers: operand classification and the response tag carried alongside the decoder.
package posit_pkg;

  typedef enum logic [1:0] {
    CLS_ZERO = 2'b00,
    CLS_NUM  = 2'b01,
    CLS_NAR  = 2'b10
  } cls_e;

  // Tag id width covers the four-lane configuration; widen when adding lanes.
  localparam int unsigned TagIdW = 2;

  typedef struct packed {
    logic              vld;
    logic [TagIdW-1:0] id;
    logic              zero;
    logic              nar;
  } tag_t;

  // Classify the low 'width' bits of op: all-zero, NaR (only MSB set) or an ordinary number.
  function automatic cls_e classify(input logic [63:0] op, input int unsigned width);
    logic [63:0] msb;
    logic [63:0] mask;
    logic [63:0] v;
    msb  = 64'd1 << (width - 1);
    mask = (msb << 1) - 64'd1;
    v    = op & mask;
    if (v == 64'd0) return CLS_ZERO;
    if (v == msb) return CLS_NAR;
    return CLS_NUM;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from the lane after the last winner, one grant per cycle.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic                 clk_i,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 en,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx
);

  localparam int unsigned IW = $clog2(N);

  logic [IW-1:0] last_q;
  logic          found;
  logic [IW-1:0] cand;

  // Pick the first requesting lane in rotating order starting at last_q+1.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IW'((32'(last_q) + k) % N);
      if (en && !found && req[cand]) begin
        gnt[cand] = 1'b1;
        idx       = cand;
        found     = 1'b1;
      end
    end
  end

  // Pointer moves only on an actual grant.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      last_q <= IW'(N - 1);
    end else if (found) begin
      last_q <= idx;
    end
  end

endmodule

// File: rtl/posit_decode_scheduler.sv
// Shares one posit decoder among NREQ lanes; zero/NaR pairs bypass it, credits guard the result FIFO.
module posit_decode_scheduler
  import posit_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned DEC_LAT = 1,
  parameter int unsigned CREDITS = 4
) (
  input  logic                    clk_i,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_vld_i,
  output logic [NREQ-1:0]         req_rdy_o,
  input  logic [NREQ*WIDTH-1:0]   req_win_i,
  input  logic [NREQ*WIDTH-1:0]   req_din_i,
  output logic                    dec_vld_o,
  output logic [WIDTH-1:0]        dec_win_o,
  output logic [WIDTH-1:0]        dec_din_o,
  output logic                    rsp_vld_o,
  output logic [$clog2(NREQ)-1:0] rsp_id_o,
  output logic                    rsp_zero_o,
  output logic                    rsp_nar_o,
  input  logic                    crd_ret_i,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam int unsigned IdW  = $clog2(NREQ);
  localparam int unsigned CrdW = $clog2(CREDITS + 1);

  logic [NREQ-1:0]  gnt;
  logic [IdW-1:0]   gnt_idx;
  logic             grant;
  logic             arb_en;
  logic [WIDTH-1:0] win_sel;
  logic [WIDTH-1:0] din_sel;
  cls_e             cls_w;
  cls_e             cls_d;
  logic             pair_zero;
  logic             pair_nar;
  logic             pair_num;
  logic [CrdW-1:0]  crd_q, crd_d;
  logic             err_q, err_d;
  logic             dec_vld_q;
  logic [WIDTH-1:0] dec_win_q, dec_din_q;
  tag_t             tag_d0;
  tag_t             tag_q [DEC_LAT+1];
  logic             busy;

  // No grants while reset is held, even though credits already read full.
  assign arb_en = !rst && (crd_q != '0);

  rr_arbiter #(
    .N(NREQ)
  ) u_arb (
    .clk_i(clk_i),
    .rst  (rst),
    .req  (req_vld_i),
    .en   (arb_en),
    .gnt  (gnt),
    .idx  (gnt_idx)
  );

  assign grant     = |gnt;
  assign req_rdy_o = gnt;
  assign win_sel   = req_win_i[gnt_idx*WIDTH +: WIDTH];
  assign din_sel   = req_din_i[gnt_idx*WIDTH +: WIDTH];

  // Classify the granted pair; zero dominates NaR.
  always_comb begin
    cls_w     = classify(64'(win_sel), WIDTH);
    cls_d     = classify(64'(din_sel), WIDTH);
    pair_zero = (cls_w == CLS_ZERO) || (cls_d == CLS_ZERO);
    pair_nar  = !pair_zero && ((cls_w == CLS_NAR) || (cls_d == CLS_NAR));
    pair_num  = !pair_zero && !pair_nar;
    tag_d0    = '0;
    if (grant) begin
      tag_d0.vld  = 1'b1;
      tag_d0.id   = TagIdW'(gnt_idx);
      tag_d0.zero = pair_zero;
      tag_d0.nar  = pair_nar;
    end
  end

  // Issue register: decoder inputs only move for NUM/NUM pairs.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      dec_vld_q <= 1'b0;
      dec_win_q <= '0;
      dec_din_q <= '0;
    end else begin
      dec_vld_q <= grant && pair_num;
      if (grant && pair_num) begin
        dec_win_q <= win_sel;
        dec_din_q <= din_sel;
      end
    end
  end

  // Tag shift register tracking the decoder's pipeline depth.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= DEC_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_d0;
      for (int i = 1; i <= DEC_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // Credit next-state; a return with credits already full is dropped and flagged.
  always_comb begin
    crd_d = crd_q;
    err_d = err_q;
    unique case ({grant, crd_ret_i})
      2'b10: crd_d = crd_q - CrdW'(1);
      2'b01: begin
        if (crd_q == CrdW'(CREDITS)) err_d = 1'b1;
        else                         crd_d = crd_q + CrdW'(1);
      end
      default: crd_d = crd_q;
    endcase
  end

  // Credit counter and sticky error.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      crd_q <= CrdW'(CREDITS);
      err_q <= 1'b0;
    end else begin
      crd_q <= crd_d;
      err_q <= err_d;
    end
  end

  // Busy while any tag stage holds a pair.
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i <= DEC_LAT; i++) busy = busy | tag_q[i].vld;
  end

  assign dec_vld_o  = dec_vld_q;
  assign dec_win_o  = dec_win_q;
  assign dec_din_o  = dec_din_q;
  assign rsp_vld_o  = tag_q[DEC_LAT].vld;
  assign rsp_id_o   = tag_q[DEC_LAT].id[IdW-1:0];
  assign rsp_zero_o = tag_q[DEC_LAT].zero;
  assign rsp_nar_o  = tag_q[DEC_LAT].nar;
  assign busy_o     = busy;
  assign err_o      = err_q;

endmodule

// File: tb/tb_posit_decode_scheduler.sv
// Bench for posit_decode_scheduler: directed scenarios plus random traffic against a queue-based model.
module tb_posit_decode_scheduler;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned NREQ    = 4;
  localparam int unsigned DEC_LAT = 1;
  localparam int unsigned CREDITS = 4;
  localparam int unsigned IdW     = $clog2(NREQ);

  logic                  clk_i = 1'b0;
  logic                  rst   = 1'b1;
  logic [NREQ-1:0]       req_vld_i = '0;
  logic [NREQ-1:0]       req_rdy_o;
  logic [NREQ*WIDTH-1:0] req_win_i = '0;
  logic [NREQ*WIDTH-1:0] req_din_i = '0;
  logic                  dec_vld_o;
  logic [WIDTH-1:0]      dec_win_o;
  logic [WIDTH-1:0]      dec_din_o;
  logic                  rsp_vld_o;
  logic [IdW-1:0]        rsp_id_o;
  logic                  rsp_zero_o;
  logic                  rsp_nar_o;
  logic                  crd_ret_i = 1'b0;
  logic                  busy_o;
  logic                  err_o;

  posit_decode_scheduler #(
    .WIDTH  (WIDTH),
    .NREQ   (NREQ),
    .DEC_LAT(DEC_LAT),
    .CREDITS(CREDITS)
  ) dut (
    .clk_i     (clk_i),
    .rst       (rst),
    .req_vld_i (req_vld_i),
    .req_rdy_o (req_rdy_o),
    .req_win_i (req_win_i),
    .req_din_i (req_din_i),
    .dec_vld_o (dec_vld_o),
    .dec_win_o (dec_win_o),
    .dec_din_o (dec_din_o),
    .rsp_vld_o (rsp_vld_o),
    .rsp_id_o  (rsp_id_o),
    .rsp_zero_o(rsp_zero_o),
    .rsp_nar_o (rsp_nar_o),
    .crd_ret_i (crd_ret_i),
    .busy_o    (busy_o),
    .err_o     (err_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Requester-side stimulus state.
  logic             lane_vld [NREQ];
  logic [WIDTH-1:0] lane_w   [NREQ];
  logic [WIDTH-1:0] lane_d   [NREQ];
  logic             ret;

  // Reference model state.
  typedef struct {
    int unsigned due;
    int          id;
    bit          zero;
    bit          nar;
  } rsp_t;

  rsp_t             m_q[$];
  int               m_last;
  int               m_crd;
  bit               m_err;
  bit               m_dvld;
  logic [WIDTH-1:0] m_dw, m_dd;
  int unsigned      cyc = 0;

  function automatic void model_reset();
    m_last = NREQ - 1;
    m_crd  = CREDITS;
    m_err  = 1'b0;
    m_dvld = 1'b0;
    m_dw   = '0;
    m_dd   = '0;
    m_q.delete();
  endfunction

  function automatic bit is_zero(input logic [WIDTH-1:0] x);
    return x == '0;
  endfunction

  function automatic bit is_nar(input logic [WIDTH-1:0] x);
    return x == (WIDTH'(1) << (WIDTH - 1));
  endfunction

  function automatic int model_pick();
    if (m_crd == 0) return -1;
    for (int k = 1; k <= NREQ; k++) begin
      int c;
      c = (m_last + k) % NREQ;
      if (lane_vld[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [WIDTH-1:0] rand_op();
    int unsigned r;
    r = $urandom_range(0, 7);
    if (r == 0) return '0;
    if (r == 1) return WIDTH'(1) << (WIDTH - 1);
    return WIDTH'($urandom);
  endfunction

  task automatic new_pair(input int lane);
    lane_w[lane] = rand_op();
    lane_d[lane] = rand_op();
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_vld_i[i]                 = lane_vld[i];
      req_win_i[i*WIDTH +: WIDTH]  = lane_w[i];
      req_din_i[i*WIDTH +: WIDTH]  = lane_d[i];
    end
    crd_ret_i = ret;
  endtask

  // One clock: drive at negedge, check grant, advance model at posedge, check outputs.
  task automatic step(output int g);
    int  pick;
    bit  z, n;
    @(negedge clk_i);
    drive();
    #1;
    pick = model_pick();
    check("req_rdy", 32'(req_rdy_o), (pick >= 0) ? (32'd1 << pick) : 32'd0);
    @(posedge clk_i);
    cyc++;
    if (pick >= 0) begin
      z = is_zero(lane_w[pick]) || is_zero(lane_d[pick]);
      n = !z && (is_nar(lane_w[pick]) || is_nar(lane_d[pick]));
      m_dvld = !z && !n;
      if (m_dvld) begin
        m_dw = lane_w[pick];
        m_dd = lane_d[pick];
      end
      m_q.push_back('{due: cyc + DEC_LAT, id: pick, zero: z, nar: n});
      m_last = pick;
      if (!ret) m_crd--;
    end else begin
      m_dvld = 1'b0;
      if (ret) begin
        if (m_crd == CREDITS) m_err = 1'b1;
        else                  m_crd++;
      end
    end
    #1;
    check("dec_vld", 32'(dec_vld_o), 32'(m_dvld));
    check("dec_win", 32'(dec_win_o), 32'(m_dw));
    check("dec_din", 32'(dec_din_o), 32'(m_dd));
    check("err", 32'(err_o), 32'(m_err));
    check("busy", 32'(busy_o), 32'(m_q.size() != 0));
    if (m_q.size() != 0 && m_q[0].due == cyc) begin
      check("rsp_vld", 32'(rsp_vld_o), 32'd1);
      check("rsp_id", 32'(rsp_id_o), 32'(m_q[0].id));
      check("rsp_zero", 32'(rsp_zero_o), 32'(m_q[0].zero));
      check("rsp_nar", 32'(rsp_nar_o), 32'(m_q[0].nar));
      void'(m_q.pop_front());
    end else begin
      check("rsp_vld_idle", 32'(rsp_vld_o), 32'd0);
    end
    g = pick;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst = 1'b1;
    #1;
    check("rst_rdy", 32'(req_rdy_o), 32'd0);
    check("rst_dec_vld", 32'(dec_vld_o), 32'd0);
    check("rst_dec_win", 32'(dec_win_o), 32'd0);
    check("rst_dec_din", 32'(dec_din_o), 32'd0);
    check("rst_rsp_vld", 32'(rsp_vld_o), 32'd0);
    check("rst_rsp_id", 32'(rsp_id_o), 32'd0);
    check("rst_rsp_zero", 32'(rsp_zero_o), 32'd0);
    check("rst_rsp_nar", 32'(rsp_nar_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    for (int i = 0; i < NREQ; i++) lane_vld[i] = 1'b0;
    ret = 1'b0;
    drive();
    @(negedge clk_i);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int g;
    for (int i = 0; i < NREQ; i++) begin
      lane_vld[i] = 1'b1;
      lane_w[i]   = 8'h11;
      lane_d[i]   = 8'h22;
    end
    ret = 1'b0;
    drive();
    do_reset();

    // All lanes valid; returns tied high from cycle 2.
    for (int i = 0; i < NREQ; i++) begin
      lane_vld[i] = 1'b1;
      new_pair(i);
    end
    for (int c = 0; c < 16; c++) begin
      ret = (c >= 2);
      step(g);
      if (g >= 0) new_pair(g);
    end
    for (int c = 0; c < 3; c++) begin
      ret = 1'b0;
      for (int i = 0; i < NREQ; i++) lane_vld[i] = 1'b0;
      step(g);
    end

    // Lane 2 alone: credits run out after four grants, one return buys one more.
    do_reset();
    lane_vld[2] = 1'b1;
    lane_w[2]   = 8'h21;
    lane_d[2]   = 8'h43;
    for (int c = 0; c < 7; c++) step(g);
    ret = 1'b1;
    step(g);
    ret = 1'b0;
    for (int c = 0; c < 4; c++) step(g);

    // Bypass classification: NUM pair, then a zero pair on lane 1, then a NaR pair on lane 3.
    do_reset();
    lane_vld[0] = 1'b1; lane_w[0] = 8'h12; lane_d[0] = 8'h34;
    step(g);
    lane_vld[0] = 1'b0;
    lane_vld[1] = 1'b1; lane_w[1] = 8'h00; lane_d[1] = 8'h35;
    step(g);
    lane_vld[1] = 1'b0;
    lane_vld[3] = 1'b1; lane_w[3] = 8'h80; lane_d[3] = 8'h40;
    step(g);
    lane_vld[3] = 1'b0;
    for (int c = 0; c < 3; c++) step(g);

    // Grant and return together at one credit, then the sticky overflow error.
    do_reset();
    lane_vld[0] = 1'b1; lane_w[0] = 8'h55; lane_d[0] = 8'h66;
    for (int c = 0; c < 3; c++) step(g);
    ret = 1'b1;
    step(g);
    ret = 1'b0;
    for (int c = 0; c < 3; c++) step(g);
    do_reset();
    ret = 1'b1;
    step(g);
    ret = 1'b0;
    for (int c = 0; c < 3; c++) step(g);

    // Reset one cycle after a grant drops the in-flight tag and rewinds the pointer.
    do_reset();
    lane_vld[1] = 1'b1; lane_w[1] = 8'h31; lane_d[1] = 8'h13;
    step(g);
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      lane_vld[i] = 1'b1;
      new_pair(i);
    end
    step(g);
    check("post_rst_lane0", 32'(g), 32'd0);
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < NREQ; i++) lane_vld[i] = 1'b0;
      step(g);
    end

    // Random traffic; pairs held until granted, returns only while credits are owed.
    do_reset();
    for (int i = 0; i < NREQ; i++) new_pair(i);
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!lane_vld[i] && ($urandom_range(0, 2) == 0)) begin
          lane_vld[i] = 1'b1;
          new_pair(i);
        end
      end
      ret = ($urandom_range(0, 1) == 1) && (m_crd < CREDITS);
      step(g);
      if (g >= 0) lane_vld[g] = ($urandom_range(0, 1) == 1);
      if (g >= 0 && lane_vld[g]) new_pair(g);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
